// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART.
// The transmitter serialises one frame per accepted request. The receiver
// synchronises the line, rejects false starts and reports good frames,
// parity errors and framing errors as one-cycle pulses.
module uart_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_busy,
    output logic                  serial_out,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  data_is_valid,
    output logic                  rx_error,
    output logic                  framing_error,
    output logic [2:0]            dbg_tx_state_o,
    output logic [2:0]            dbg_rx_state_o
);

    localparam int CW = $clog2(CLOCKS_PER_BIT + 1);
    localparam int IW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] CNT_FULL = CW'(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    localparam logic PAR_EN    = (PARITY_MODE != 0);
    localparam logic PAR_ODD   = (PARITY_MODE == 2);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE
    } rx_state_e;

    // ------------------------------------------------------------------
    // Transmitter
    // Handshake: a request is taken in any cycle where enable=1 and
    // o_busy=0; i_data is captured in that cycle. enable while o_busy=1 is
    // dropped, not queued.
    // ------------------------------------------------------------------
    tx_state_e             tx_state_q, tx_state_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [IW-1:0]         tx_idx_q, tx_idx_d;
    logic                  tx_stop_q, tx_stop_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  serial_out_q, serial_out_d;
    logic                  busy_q, busy_d;
    logic                  tx_cnt_last;

    assign tx_cnt_last = (tx_cnt_q == CNT_LAST);

    // TX next state: each bit is held for CLOCKS_PER_BIT cycles; the line
    // value for the next bit is registered at the boundary.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_idx_d     = tx_idx_q;
        tx_stop_d    = tx_stop_q;
        tx_shift_d   = tx_shift_q;
        tx_par_d     = tx_par_q;
        serial_out_d = serial_out_q;
        busy_d       = busy_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (enable) begin
                    tx_state_d   = TX_START;
                    tx_cnt_d     = '0;
                    tx_shift_d   = i_data;
                    tx_par_d     = (^i_data) ^ PAR_ODD;
                    serial_out_d = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_last) begin
                    tx_state_d   = TX_DATA;
                    tx_cnt_d     = '0;
                    tx_idx_d     = '0;
                    serial_out_d = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_last) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == IDX_LAST) begin
                        tx_stop_d = 1'b0;
                        if (PAR_EN) begin
                            tx_state_d   = TX_PARITY;
                            serial_out_d = tx_par_q;
                        end else begin
                            tx_state_d   = TX_STOP;
                            serial_out_d = 1'b1;
                        end
                    end else begin
                        tx_idx_d     = tx_idx_q + 1'b1;
                        tx_shift_d   = tx_shift_q >> 1;
                        serial_out_d = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_last) begin
                    tx_state_d   = TX_STOP;
                    tx_cnt_d     = '0;
                    tx_stop_d    = 1'b0;
                    serial_out_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_last) begin
                    tx_cnt_d = '0;
                    if (tx_stop_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                        busy_d     = 1'b0;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d   = TX_IDLE;
                serial_out_d = 1'b1;
                busy_d       = 1'b0;
            end
        endcase
    end

    // TX state register; reset parks the line high and drops busy at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_idx_q     <= '0;
            tx_stop_q    <= 1'b0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            serial_out_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            tx_stop_q    <= tx_stop_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            serial_out_q <= serial_out_d;
            busy_q       <= busy_d;
        end
    end

    assign serial_out     = serial_out_q;
    assign o_busy         = busy_q;
    assign dbg_tx_state_o = tx_state_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                  rx_meta_q, rx_s_q;
    rx_state_e             rx_state_q, rx_state_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [IW-1:0]         rx_idx_q, rx_idx_d;
    logic                  rx_stop_q, rx_stop_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_ferr_q, rx_ferr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  valid_q, valid_d;
    logic                  perr_out_q, perr_out_d;
    logic                  ferr_out_q, ferr_out_d;
    logic                  rx_sample;
    logic                  ferr_now;

    // Two-flop synchroniser; both flops reset high so reset never looks
    // like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // The counter is loaded with C/2 at the falling edge and with C after
    // every sample; a bit is sampled when it reaches one, which puts the
    // start sample C/2 cycles after the edge and every later sample exactly
    // C cycles after the previous one.
    assign rx_sample = (rx_cnt_q == CNT_ONE);
    assign ferr_now  = rx_ferr_q | ~rx_s_q;

    // RX next state. Result pulses are computed at the last stop sample so
    // they are registered and visible during the DONE cycle.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_stop_d  = rx_stop_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rdata_d    = rdata_q;
        valid_d    = 1'b0;
        perr_out_d = 1'b0;
        ferr_out_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = CNT_HALF;
                    rx_perr_d  = 1'b0;
                    rx_ferr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    if (rx_s_q) begin
                        rx_state_d = RX_IDLE;  // false start
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = CNT_FULL;
                        rx_idx_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_cnt_d   = CNT_FULL;
                    rx_shift_d = {rx_s_q, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_stop_d  = 1'b0;
                        rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_cnt_d   = CNT_FULL;
                    rx_stop_d  = 1'b0;
                    rx_perr_d  = rx_s_q ^ (^rx_shift_q) ^ PAR_ODD;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_cnt_d  = CNT_FULL;
                    rx_ferr_d = ferr_now;
                    if (rx_stop_q == STOP_LAST) begin
                        rx_state_d = RX_DONE;
                        rdata_d    = rx_shift_q;
                        ferr_out_d = ferr_now;
                        perr_out_d = ~ferr_now & rx_perr_q;
                        valid_d    = ~ferr_now & ~rx_perr_q;
                    end else begin
                        rx_stop_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DONE: begin
                // After a framing error hold here until the line is high,
                // so a long break reports only once.
                if (!(rx_ferr_q && !rx_s_q)) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX state register; reset aborts any frame without a pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_stop_q  <= 1'b0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_stop_q  <= rx_stop_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    assign received_data  = rdata_q;
    assign data_is_valid  = valid_q;
    assign rx_error       = perr_out_q;
    assign framing_error  = ferr_out_q;
    assign dbg_rx_state_o = rx_state_q;

endmodule
